// File: rtl/sram_ctrl.sv
// Asynchronous SRAM burst controller: SETUP / ACCESS / HOLD beat sequencing with
// registered strobes, auto-incrementing address and per-beat write/read handshakes.
//
//   state  | meaning
//   IDLE   | strobes inactive, waiting for a read/write request
//   SETUP  | chip enabled, address settled, write word fetched
//   ACCESS | n_oe (read) or n_we+de (write) active for WAIT_CYC cycles
//   HOLD   | strobes released, address and write data held one cycle
module sram_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 11,
  parameter int WAIT_CYC = 2,
  parameter int BL_W     = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [BL_W-1:0]   burst_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              de,
  output logic              n_ce,
  output logic              n_oe,
  output logic              n_we
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

  state_t            r_state;
  logic              r_is_wr;
  logic [BL_W-1:0]   r_beats;
  logic [3:0]        r_wait;
  logic              r_wdata_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_dq_out;
  logic              r_de;
  logic              r_n_ce;
  logic              r_n_oe;
  logic              r_n_we;

  // Outputs are driven for the state being entered, so every port comes straight from a flop.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= IDLE;
      r_is_wr       <= 1'b0;
      r_beats       <= '0;
      r_wait        <= '0;
      r_wdata_ack   <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_de          <= 1'b0;
      r_n_ce        <= 1'b1;
      r_n_oe        <= 1'b1;
      r_n_we        <= 1'b1;
    end else begin
      r_wdata_ack   <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (write || read) begin
            r_is_wr     <= write;
            r_sram_addr <= addr_in;
            r_beats     <= burst_len;
            r_busy      <= 1'b1;
            r_n_ce      <= 1'b0;
            r_wdata_ack <= write;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_wait  <= WAIT_LAST;
          r_state <= ACCESS;
          if (r_is_wr) begin
            r_sram_dq_out <= wdata;
            r_n_we        <= 1'b0;
            r_de          <= 1'b1;
          end else begin
            r_n_oe <= 1'b0;
          end
        end
        ACCESS: begin
          if (r_wait == 4'd0) begin
            r_n_we  <= 1'b1;
            r_n_oe  <= 1'b1;
            r_done  <= (r_beats == '0);
            r_state <= HOLD;
            if (!r_is_wr) begin
              r_rdata       <= sram_dq_in;
              r_rdata_valid <= 1'b1;
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        HOLD: begin
          r_de <= 1'b0;
          if (r_beats != '0) begin
            r_beats     <= r_beats - BL_W'(1);
            r_sram_addr <= r_sram_addr + ADDR_W'(1);
            r_wdata_ack <= r_is_wr;
            r_state     <= SETUP;
          end else begin
            r_busy  <= 1'b0;
            r_n_ce  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wdata_ack   = r_wdata_ack;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_sram_dq_out;
  assign de          = r_de;
  assign n_ce        = r_n_ce;
  assign n_oe        = r_n_oe;
  assign n_we        = r_n_we;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: directed bursts push expected beats, a negedge
// monitor pops and compares them as the controller presents strobes and pulses.
module tb_sram_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 11;
  localparam int W   = 2;
  localparam int BLW = 4;
  localparam int BC  = W + 2;

  logic           clock = 1'b0;
  logic           n_reset = 1'b1;
  logic           read = 1'b0;
  logic           write = 1'b0;
  logic [AW-1:0]  addr_in = '0;
  logic [BLW-1:0] burst_len = '0;
  logic [DW-1:0]  wdata;
  logic           wdata_ack, rdata_valid, busy, done, de, n_ce, n_oe, n_we;
  logic [DW-1:0]  rdata, sram_dq_out, sram_dq_in;
  logic [AW-1:0]  sram_addr;

  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(W), .BL_W(BLW)) dut (
    .clock(clock), .n_reset(n_reset), .read(read), .write(write),
    .addr_in(addr_in), .burst_len(burst_len), .wdata(wdata),
    .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .de(de), .n_ce(n_ce), .n_oe(n_oe), .n_we(n_we)
  );

  always #5 clock = ~clock;

  // SRAM model returns the low address byte
  assign sram_dq_in = sram_addr[7:0];

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; int cyc;} beat_t;
  typedef struct {logic wr; int nbeats; int done_cyc;} burst_t;

  beat_t  exp_rd[$];
  beat_t  exp_wr[$];
  burst_t exp_b[$];

  logic [DW-1:0] wtab[32];
  logic [4:0]    widx = '0;
  logic [4:0]    wpos = '0;
  assign wdata = wtab[widx];

  int n_pass = 0, n_chk = 0;
  int ack_cnt = 0, done_cnt = 0, viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic push_b(input logic wr, input int nb);
    burst_t b;
    b.wr = wr; b.nbeats = nb; b.done_cyc = nb * BC;
    exp_b.push_back(b);
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input int beat);
    beat_t e;
    e.addr = a; e.data = d; e.cyc = beat * BC + 2;
    exp_wr.push_back(e);
    wtab[wpos] = d;
    wpos = wpos + 5'd1;
  endtask

  task automatic push_r(input logic [AW-1:0] a, input logic [DW-1:0] d, input int beat);
    beat_t e;
    e.addr = a; e.data = d; e.cyc = (beat + 1) * BC;
    exp_rd.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [BLW-1:0] bl);
    @(negedge clock);
    write = wr; read = rd; addr_in = a; burst_len = bl;
    @(posedge clock);
    #1 write = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 200);
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // requester side: next write word is presented after the consuming edge
  initial begin
    forever begin
      @(negedge clock);
      if (wdata_ack && n_reset) begin
        @(posedge clock);
        #1 widx = widx + 5'd1;
      end
    end
  end

  // monitor / scoreboard
  logic   prev_busy = 1'b0, prev_nwe = 1'b1, has_cur = 1'b0;
  int     cyc = 0, beats_seen = 0, low_cnt = 0, exp_fall = 0;
  burst_t cur;
  beat_t  cur_wr, e;

  initial begin
    cur_wr.addr = '0; cur_wr.data = '0; cur_wr.cyc = 0;
    forever begin
      @(negedge clock);
      if (!n_reset) begin
        prev_busy = 1'b0;
        prev_nwe  = 1'b1;
        has_cur   = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          cyc = 1;
          beats_seen = 0;
          if (exp_b.size() == 0) begin
            fail_evt("unexpected_burst");
            has_cur = 1'b0;
          end else begin
            cur = exp_b.pop_front();
            has_cur = 1'b1;
          end
        end else begin
          cyc++;
        end

        if ((!n_oe && !n_we) || (de && !n_oe) ||
            (has_cur && cur.wr && !n_oe) || (has_cur && !cur.wr && (!n_we || de))) begin
          viol++;
          if (viol < 5) $display("FAIL proto: n_oe=%b n_we=%b de=%b at t=%0t", n_oe, n_we, de, $time);
        end

        if (wdata_ack) begin
          ack_cnt++;
          if (has_cur && cur.wr) beats_seen++;
        end

        if (!n_we && prev_nwe) begin
          low_cnt = 1;
          if (exp_wr.size() == 0) fail_evt("unexpected_write");
          else begin
            cur_wr = exp_wr.pop_front();
            chk("wr_addr", 32'(sram_addr), 32'(cur_wr.addr));
            chk("wr_data", 32'(sram_dq_out), 32'(cur_wr.data));
            chk("wr_cyc", 32'(cyc), 32'(cur_wr.cyc));
          end
        end else if (!n_we) begin
          low_cnt++;
        end

        if (n_we && !prev_nwe)
          chk("wr_hold", {8'd0, de, sram_dq_out, sram_addr, 4'(low_cnt)},
              {8'd0, 1'b1, cur_wr.data, cur_wr.addr, 4'(W)});

        if (rdata_valid) begin
          if (has_cur && !cur.wr) beats_seen++;
          if (exp_rd.size() == 0) fail_evt("unexpected_rdata");
          else begin
            e = exp_rd.pop_front();
            chk("rd_data", 32'(rdata), 32'(e.data));
            chk("rd_addr", 32'(sram_addr), 32'(e.addr));
            chk("rd_cyc", 32'(cyc), 32'(e.cyc));
          end
        end

        if (done) begin
          done_cnt++;
          if (!has_cur) fail_evt("unexpected_done");
          else begin
            chk("done_beats", 32'(beats_seen), 32'(cur.nbeats));
            chk("done_cyc", 32'(cyc), 32'(cur.done_cyc));
            exp_fall = cur.done_cyc + 1;
          end
        end

        if (!busy && prev_busy) begin
          chk("busy_fall_cyc", 32'(cyc), 32'(exp_fall));
          has_cur = 1'b0;
        end

        prev_busy = busy;
        prev_nwe  = n_we;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) wtab[i] = '0;

    // asynchronous reset, checked before any clock edge
    #2 n_reset = 1'b0;
    #1;
    chk("rst_strobes", {29'd0, n_ce, n_oe, n_we}, 32'h7);
    chk("rst_flags", {27'd0, de, busy, done, rdata_valid, wdata_ack}, 32'h0);
    chk("rst_data", {5'd0, rdata, sram_dq_out, sram_addr}, 32'h0);
    repeat (2) @(posedge clock);
    #2 n_reset = 1'b1;

    // single write
    push_b(1'b1, 1);
    push_w(11'h010, 8'hA5, 0);
    issue(1'b1, 1'b0, 11'h010, 4'd0);
    wait_idle("t_single_write");

    // read burst wrapping the address
    push_b(1'b0, 4);
    push_r(11'h7FE, 8'hFE, 0);
    push_r(11'h7FF, 8'hFF, 1);
    push_r(11'h000, 8'h00, 2);
    push_r(11'h001, 8'h01, 3);
    issue(1'b0, 1'b1, 11'h7FE, 4'd3);
    wait_idle("t_read_burst");

    // read and write together: write wins
    push_b(1'b1, 1);
    push_w(11'h123, 8'h3C, 0);
    issue(1'b1, 1'b1, 11'h123, 4'd0);
    wait_idle("t_both");

    // read pulse during ACCESS of a two-beat write is ignored
    push_b(1'b1, 2);
    push_w(11'h7FF, 8'h11, 0);
    push_w(11'h000, 8'h22, 1);
    issue(1'b1, 1'b0, 11'h7FF, 4'd1);
    @(posedge clock);
    #2 read = 1'b1;
    @(posedge clock);
    #1 read = 1'b0;
    wait_idle("t_req_busy");

    // reset during ACCESS of beat 2
    push_b(1'b1, 3);
    push_w(11'h200, 8'h44, 0);
    push_w(11'h201, 8'h55, 1);
    push_w(11'h202, 8'h66, 2);
    issue(1'b1, 1'b0, 11'h200, 4'd2);
    repeat (5) @(posedge clock);
    #2 n_reset = 1'b0;
    #1;
    chk("abort_nwe", 32'(n_we), 32'd1);
    chk("abort_de", 32'(de), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_wr.delete();
    exp_b.delete();
    wpos = widx;
    repeat (2) @(posedge clock);
    #2 n_reset = 1'b1;

    push_b(1'b1, 1);
    push_w(11'h300, 8'h99, 0);
    issue(1'b1, 1'b0, 11'h300, 4'd0);
    wait_idle("t_after_reset");

    // read held high: the HOLD->IDLE edge ignores it, next edge restarts
    push_b(1'b0, 1);
    push_r(11'h005, 8'h05, 0);
    push_b(1'b0, 1);
    push_r(11'h005, 8'h05, 0);
    @(negedge clock);
    addr_in = 11'h005; burst_len = 4'd0; read = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("idle_gap_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1 read = 1'b0;
    @(negedge clock);
    chk("rerequest_busy", 32'(busy), 32'd1);
    wait_idle("t_held_read");

    repeat (3) @(negedge clock);
    chk("ack_count", 32'(ack_cnt), 32'd7);
    chk("done_count", 32'(done_cnt), 32'd7);
    chk("proto_violations", 32'(viol), 32'd0);
    chk("queues_drained", 32'(exp_rd.size() + exp_wr.size() + exp_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: SRAM data bus width in bits.
REQ-002 Parameter ADDR_W, default 11: SRAM address width; addressable depth 2^ADDR_W words.
REQ-003 Parameter WAIT_CYC, default 2 (legal range 1..15): strobe-active cycles per beat.
REQ-004 Parameter BL_W, default 4: burst-length field width.
REQ-005 Port list (name, direction, width, meaning):
- clock  in  1  system clock; all state changes on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- read  in  1  read request, sampled in IDLE only.
- write  in  1  write request, sampled in IDLE only.
- addr_in  in  ADDR_W  burst start address, captured with the request.
- burst_len  in  BL_W  beats minus one, captured with the request.
- wdata  in  DATA_W  write data for the current beat.
- wdata_ack  out  1  one-cycle pulse; wdata is consumed on this edge, and the requester presents the next word afterwards.
- rdata  out  DATA_W  last word read.
- rdata_valid  out  1  one-cycle pulse; rdata holds a new word.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on the final beat of a burst.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_out  out  DATA_W  write data to the SRAM.
- sram_dq_in  in  DATA_W  read data from the SRAM.
- de  out  1  data-bus drive enable (write direction).
- n_ce  out  1  chip enable, active-low.
- n_oe  out  1  output enable, active-low.
- n_we  out  1  write enable, active-low.

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, ACCESS and HOLD; every output SHALL be registered.
REQ-007 IDLE outputs SHALL be: n_ce=n_oe=n_we=1, de=0, busy=0.
REQ-008 In IDLE, a high write or read on a rising edge SHALL start a burst:
- capture addr_in, burst_len and the operation;
- write takes priority when both are high;
- enter SETUP with busy=1.
REQ-009 Requests outside IDLE SHALL be ignored and never queued.
REQ-010 SETUP SHALL last 1 cycle with n_ce=0 and n_oe=n_we=1.
- For a write beat: wdata_ack=1, and sram_dq_out loads wdata at the end of SETUP.
REQ-011 ACCESS SHALL last exactly WAIT_CYC cycles with n_ce=0.
- Read: n_oe=0.
- Write: n_we=0 and de=1.
REQ-012 HOLD SHALL last 1 cycle with n_ce=0 and n_oe=n_we=1.
- A write keeps de=1 and sram_dq_out stable (data hold).
REQ-013 On a read, rdata SHALL load sram_dq_in on the edge that ends the last ACCESS cycle; rdata_valid=1 for exactly the HOLD cycle.
REQ-014 sram_addr SHALL be constant from SETUP through HOLD of a beat.
REQ-015 After HOLD:
- If beats remain, sram_addr SHALL increment by 1, wrapping from 2^ADDR_W-1 to 0, and the FSM SHALL enter SETUP.
- Otherwise the FSM SHALL enter IDLE.
REQ-016 A burst SHALL comprise burst_len+1 beats; each beat takes WAIT_CYC+2 cycles.
REQ-017 done SHALL be 1 during the HOLD cycle of the final beat only.
REQ-018 A request present on the edge leaving HOLD into IDLE SHALL be ignored; the earliest new burst starts one cycle after IDLE is entered.
REQ-019 n_we and n_oe SHALL never be low simultaneously, and de SHALL never be 1 during a read.

Reset
REQ-020 n_reset low SHALL immediately, without waiting for a clock edge, force:
- the FSM to IDLE;
- n_ce=n_oe=n_we=1, de=0;
- busy=done=rdata_valid=wdata_ack=0;
- rdata, sram_addr and sram_dq_out to 0.
REQ-021 Reset asserted mid-burst SHALL abort the burst without a done pulse.
- The first rising edge after deassertion SHALL sample requests normally.

Verification (defaults, WAIT_CYC=2)
REQ-022 Single write: write=1, addr_in=0x010, burst_len=0, wdata=0xA5.
- Expect SETUP(1), n_we low 2 cycles, HOLD(1), and sram_dq_out=0xA5 with de=1 across ACCESS+HOLD.
- Expect done in cycle 4 and busy low in cycle 5.
REQ-023 Read burst: read=1, addr_in=0x7FE, burst_len=3, with the model returning addr[7:0].
- Expect addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Expect rdata 0xFE, 0xFF, 0x00, 0x01 with four rdata_valid pulses 4 cycles apart.
- Expect done with the 4th rdata_valid.
REQ-024 Simultaneous read=1 and write=1 in IDLE: expect a write (n_we toggles, n_oe stays 1).
REQ-025 Request while busy: pulse read during the ACCESS of a write burst; expect no extra beat and unchanged burst length.
REQ-026 Reset mid-burst: assert n_reset during ACCESS of beat 2 of a write burst.
- Expect n_we=1, de=0 and busy=0 within the same cycle, and no done pulse.
- A write request after release completes normally.
REQ-027 Protocol checker throughout: n_oe and n_we never both 0; de never 1 while n_oe=0; wdata_ack count equals write beats.
